// File: rtl/mem_port_arbiter_if.sv
// Bundle of the core-side IF/LS request ports and the memory-side bus of mem_port_arbiter.
// Latency: none (wires only).
// Backpressure: req is held by the requester until its ack pulse.
interface mem_port_arbiter_if #(
  parameter int AW = 8,
  parameter int DW = 32
);
  // instruction-fetch port
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_ack;
  logic [DW-1:0] if_rdata;
  // load/store port
  logic          ls_req;
  logic          ls_we;
  logic [3:0]    ls_be;
  logic [AW-1:0] ls_addr;
  logic [DW-1:0] ls_wdata;
  logic          ls_ack;
  logic [DW-1:0] ls_rdata;
  // memory side
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  // core pipeline plus memory instance
  modport master (
    output if_req, if_addr, ls_req, ls_we, ls_be, ls_addr, ls_wdata, mem_rdata,
    input  if_ack, if_rdata, ls_ack, ls_rdata, mem_we, mem_addr, mem_wdata
  );

  // the arbiter
  modport slave (
    input  if_req, if_addr, ls_req, ls_we, ls_be, ls_addr, ls_wdata, mem_rdata,
    output if_ack, if_rdata, ls_ack, ls_rdata, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one 256x32 single-port memory between IF and LS; reads, full stores, byte-masked RMW stores.
// Latency: read / full / no-op store ack 2 cycles after req, RMW store 3 cycles; one access per requester per 3 cycles.
// Backpressure: req held until ack; MEM_ARB_ROUND_ROBIN_EN selects round-robin instead of LS-over-IF priority.
module mem_port_arbiter #(
  parameter int AW = 8,
  parameter int DW = 32
) (
  input  logic                i_clk,
  input  logic                i_rst,
  mem_port_arbiter_if.slave   io_bus,
  output logic                o_busy
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_IF_RD  = 3'd1,
    S_LS_RD  = 3'd2,
    S_RMW_RD = 3'd3,
    S_LS_WR  = 3'd4
  } state_t;

  state_t        r_state;
  logic          r_last_grant_ls;   // 0 = IF was granted last, 1 = LS
  logic [3:0]    r_be;
  logic [DW-1:0] r_wdata;
  logic          r_if_ack;
  logic          r_ls_ack;
  logic          r_mem_we;
  logic          r_busy;
  logic [AW-1:0] r_mem_addr;
  logic [DW-1:0] r_mem_wdata;
  logic [DW-1:0] r_if_rdata;
  logic [DW-1:0] r_ls_rdata;

  logic          w_if_elig;
  logic          w_ls_elig;
  logic          w_prefer_ls;
  logic          w_grant_ls;
  logic          w_grant_if;
  logic [DW-1:0] w_merged;

  // A port whose ack is high this cycle still shows req; it must not be re-granted.
  assign w_if_elig = io_bus.if_req & ~r_if_ack;
  assign w_ls_elig = io_bus.ls_req & ~r_ls_ack;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // On a tie, the port that did not win last time goes first.
  assign w_prefer_ls = ~r_last_grant_ls;
`else
  // Fixed LS priority; last_grant is tracked but does not influence the tie-break.
  assign w_prefer_ls = 1'b1 | r_last_grant_ls;
`endif

  assign w_grant_ls = w_ls_elig & (~w_if_elig | w_prefer_ls);
  assign w_grant_if = w_if_elig & ~w_grant_ls;

  // Byte merge of the latched store data over the current memory word.
  always_comb begin
    w_merged = io_bus.mem_rdata;
    for (int i = 0; i < 4; i++) begin
      if (r_be[i]) begin
        w_merged[8*i +: 8] = r_wdata[8*i +: 8];
      end
    end
  end

  // Access sequencer: arbitration, memory strobes and registered responses.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state         <= S_IDLE;
      r_last_grant_ls <= 1'b0;
      r_be            <= 4'h0;
      r_wdata         <= '0;
      r_if_ack        <= 1'b0;
      r_ls_ack        <= 1'b0;
      r_mem_we        <= 1'b0;
      r_busy          <= 1'b0;
      r_mem_addr      <= '0;
      r_mem_wdata     <= '0;
      r_if_rdata      <= '0;
      r_ls_rdata      <= '0;
    end else begin
      r_if_ack <= 1'b0;
      r_ls_ack <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_grant_ls) begin
            r_last_grant_ls <= 1'b1;
            r_mem_addr      <= io_bus.ls_addr;
            r_be            <= io_bus.ls_be;
            r_wdata         <= io_bus.ls_wdata;
            r_busy          <= 1'b1;
            if (!io_bus.ls_we) begin
              r_state <= S_LS_RD;
            end else if (io_bus.ls_be == 4'hF) begin
              r_state     <= S_LS_WR;
              r_mem_we    <= 1'b1;
              r_mem_wdata <= io_bus.ls_wdata;
            end else if (io_bus.ls_be == 4'h0) begin
              // Empty mask: walk through LS_WR without strobing so the ack timing matches a full store.
              r_state <= S_LS_WR;
            end else begin
              r_state <= S_RMW_RD;
            end
          end else if (w_grant_if) begin
            r_last_grant_ls <= 1'b0;
            r_mem_addr      <= io_bus.if_addr;
            r_busy          <= 1'b1;
            r_state         <= S_IF_RD;
          end
        end
        S_IF_RD: begin
          r_if_rdata <= io_bus.mem_rdata;
          r_if_ack   <= 1'b1;
          r_busy     <= 1'b0;
          r_state    <= S_IDLE;
        end
        S_LS_RD: begin
          r_ls_rdata <= io_bus.mem_rdata;
          r_ls_ack   <= 1'b1;
          r_busy     <= 1'b0;
          r_state    <= S_IDLE;
        end
        S_RMW_RD: begin
          r_mem_wdata <= w_merged;
          r_mem_we    <= 1'b1;
          r_state     <= S_LS_WR;
        end
        S_LS_WR: begin
          // The memory committed at the falling edge inside this cycle.
          r_mem_we <= 1'b0;
          r_ls_ack <= 1'b1;
          r_busy   <= 1'b0;
          r_state  <= S_IDLE;
        end
        default: begin
          r_mem_we <= 1'b0;
          r_busy   <= 1'b0;
          r_state  <= S_IDLE;
        end
      endcase
    end
  end

  assign io_bus.if_ack    = r_if_ack;
  assign io_bus.if_rdata  = r_if_rdata;
  assign io_bus.ls_ack    = r_ls_ack;
  assign io_bus.ls_rdata  = r_ls_rdata;
  assign io_bus.mem_we    = r_mem_we;
  assign io_bus.mem_addr  = r_mem_addr;
  assign io_bus.mem_wdata = r_mem_wdata;
  assign o_busy           = r_busy;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed IF/LS accesses against a behavioural memory.
// Latency: expected ack cycles are carried in the scoreboard entries.
// Backpressure: drivers hold req until ack, with a bounded wait.
module tb_mem_port_arbiter;

  typedef struct {
    logic [31:0] d;
    logic        chk;
    int          cyc;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        busy;
  int          cyc;
  int          n_vec;
  int          n_bad;
  int          we_cnt;
  logic [7:0]  we_addr;
  logic [31:0] mem [0:255];
  logic        pre_vld;
  logic [7:0]  pre_addr;
  logic [31:0] pre_dat;
  exp_t        exp_if[$];
  exp_t        exp_ls[$];

  mem_port_arbiter_if #(.AW(8), .DW(32)) bus();

  mem_port_arbiter #(.AW(8), .DW(32)) dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .io_bus (bus),
    .o_busy (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // cycle counter, updated on every rising edge
  always @(posedge clk) cyc <= cyc + 1;

  // memory model: combinational read, falling-edge write; preload path for setup
  assign bus.mem_rdata = mem[bus.mem_addr];
  always @(negedge clk) begin
    if (pre_vld) mem[pre_addr] <= pre_dat;
    else if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // monitor: pop the scoreboard whenever an ack is presented
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (bus.if_ack) begin
        if (exp_if.size() == 0) check("if_ack_unexpected", 32'd1, 32'd0);
        else begin
          e = exp_if.pop_front();
          check("if_ack_cycle", 32'(cyc), 32'(e.cyc));
          if (e.chk) check("if_rdata", bus.if_rdata, e.d);
        end
      end
      if (bus.ls_ack) begin
        if (exp_ls.size() == 0) check("ls_ack_unexpected", 32'd1, 32'd0);
        else begin
          e = exp_ls.pop_front();
          check("ls_ack_cycle", 32'(cyc), 32'(e.cyc));
          if (e.chk) check("ls_rdata", bus.ls_rdata, e.d);
        end
      end
      if (bus.mem_we) begin
        we_cnt++;
        we_addr = bus.mem_addr;
      end
    end
  end

  task automatic preload(input logic [7:0] a, input logic [31:0] d);
    pre_addr = a;
    pre_dat  = d;
    pre_vld  = 1'b1;
    @(negedge clk);
    #1;
    pre_vld = 1'b0;
  endtask

  task automatic do_if(input logic [7:0] a, input logic [31:0] d, input int lat);
    exp_t e;
    @(posedge clk);
    #1;
    e.d = d; e.chk = 1'b1; e.cyc = cyc + lat;
    exp_if.push_back(e);
    bus.if_addr = a;
    bus.if_req  = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      #1;
      if (bus.if_ack) break;
    end
    if (!bus.if_ack) check("if_ack_timeout", 32'd0, 32'd1);
    bus.if_req = 1'b0;
  endtask

  task automatic do_ls(input logic we, input logic [3:0] be, input logic [7:0] a,
                       input logic [31:0] wd, input logic [31:0] d, input int lat);
    exp_t e;
    @(posedge clk);
    #1;
    e.d = d; e.chk = ~we; e.cyc = cyc + lat;
    exp_ls.push_back(e);
    bus.ls_we    = we;
    bus.ls_be    = be;
    bus.ls_addr  = a;
    bus.ls_wdata = wd;
    bus.ls_req   = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      #1;
      if (bus.ls_ack) break;
    end
    if (!bus.ls_ack) check("ls_ack_timeout", 32'd0, 32'd1);
    bus.ls_req = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_if_ack"},    32'(bus.if_ack),   32'd0);
    check({tag, "_ls_ack"},    32'(bus.ls_ack),   32'd0);
    check({tag, "_mem_we"},    32'(bus.mem_we),   32'd0);
    check({tag, "_busy"},      32'(busy),         32'd0);
    check({tag, "_mem_addr"},  32'(bus.mem_addr), 32'd0);
    check({tag, "_mem_wdata"}, bus.mem_wdata,     32'd0);
    check({tag, "_if_rdata"},  bus.if_rdata,      32'd0);
    check({tag, "_ls_rdata"},  bus.ls_rdata,      32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int w0;
    n_vec = 0; n_bad = 0; we_cnt = 0; we_addr = 8'h00; cyc = 0;
    pre_vld = 1'b0; pre_addr = 8'h00; pre_dat = 32'h0;
    bus.if_req = 1'b0; bus.if_addr = 8'h00;
    bus.ls_req = 1'b0; bus.ls_we = 1'b0; bus.ls_be = 4'h0;
    bus.ls_addr = 8'h00; bus.ls_wdata = 32'h0;
    rst = 1'b1;

    // setup memory while in reset
    preload(8'h10, 32'h00500093);
    preload(8'h21, 32'h11223344);
    preload(8'h30, 32'hCAFEF00D);
    preload(8'h00, 32'h0BADF00D);
    preload(8'hFF, 32'h87654321);
    preload(8'h40, 32'h5A5A5A5A);
    check_reset_outputs("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;

    // instruction fetch
    w0 = we_cnt;
    do_if(8'h10, 32'h00500093, 2);
    check("if_no_write", 32'(we_cnt - w0), 32'd0);

    // full-word store then load-back
    w0 = we_cnt;
    do_ls(1'b1, 4'hF, 8'h20, 32'hDEADBEEF, 32'h0, 2);
    check("full_we_cycles", 32'(we_cnt - w0), 32'd1);
    check("full_we_addr", 32'(we_addr), 32'h20);
    check("full_mem", mem[8'h20], 32'hDEADBEEF);
    do_ls(1'b0, 4'h0, 8'h20, 32'h0, 32'hDEADBEEF, 2);

    // byte-masked read-modify-write
    w0 = we_cnt;
    do_ls(1'b1, 4'b0101, 8'h21, 32'hAABBCCDD, 32'h0, 3);
    check("rmw_we_cycles", 32'(we_cnt - w0), 32'd1);
    check("rmw_mem", mem[8'h21], 32'h11BB33DD);

    // empty byte mask: acked, no write
    w0 = we_cnt;
    do_ls(1'b1, 4'h0, 8'h30, 32'h01020304, 32'h0, 2);
    check("noop_we_cycles", 32'(we_cnt - w0), 32'd0);
    check("noop_mem", mem[8'h30], 32'hCAFEF00D);

    // address extremes
    do_if(8'h00, 32'h0BADF00D, 2);
    do_ls(1'b0, 4'h0, 8'hFF, 32'h0, 32'h87654321, 2);

    // simultaneous requests; last grant was LS
`ifdef MEM_ARB_ROUND_ROBIN_EN
    fork
      do_if(8'h10, 32'h00500093, 2);
      do_ls(1'b0, 4'h0, 8'h20, 32'h0, 32'hDEADBEEF, 4);
    join
`else
    fork
      do_if(8'h10, 32'h00500093, 4);
      do_ls(1'b0, 4'h0, 8'h20, 32'h0, 32'hDEADBEEF, 2);
    join
`endif
    repeat (3) @(posedge clk);
    #1;
    check("sim_if_all_acked", 32'(exp_if.size()), 32'd0);
    check("sim_ls_all_acked", 32'(exp_ls.size()), 32'd0);

    // reset while the store strobe is high, before the falling edge
    @(posedge clk);
    #1;
    bus.ls_we = 1'b1; bus.ls_be = 4'hF; bus.ls_addr = 8'h40;
    bus.ls_wdata = 32'h12345678; bus.ls_req = 1'b1;
    @(posedge clk);
    #1;
    check("rst_mid_we_before", 32'(bus.mem_we), 32'd1);
    rst = 1'b1;
    #1;
    check("rst_mid_we_drop", 32'(bus.mem_we), 32'd0);
    @(negedge clk);
    #1;
    check("rst_mid_mem", mem[8'h40], 32'h5A5A5A5A);
    check_reset_outputs("rst_mid");
    bus.ls_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("rst_mid_mem_after", mem[8'h40], 32'h5A5A5A5A);
    check("final_if_queue", 32'(exp_if.size()), 32'd0);
    check("final_ls_queue", 32'(exp_ls.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
